// File: rtl/wb_queue_if.sv
// Bundle of the result-input, register-file write, hazard-check and status
// signals of the writeback queue. The slave modport is the queue's side.
interface wb_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid1;
  logic [4:0]    in_rd1;
  logic [31:0]   in_data1;
  logic          in_valid2;
  logic [4:0]    in_rd2;
  logic [31:0]   in_data2;
  logic          in_ready;
  logic          wb_stall;
  logic          flush;
  logic          reg_write;
  logic [4:0]    regd;
  logic [31:0]   write_data;
  logic          reg_write2;
  logic [4:0]    regd2;
  logic [31:0]   write_data2;
  logic [4:0]    chk_reg1;
  logic [4:0]    chk_reg2;
  logic [4:0]    chk_reg3;
  logic [4:0]    chk_reg4;
  logic [3:0]    chk_hit;
  logic [CW-1:0] count;
  logic          err_overflow;

  modport slave (
    input  in_valid1, in_rd1, in_data1, in_valid2, in_rd2, in_data2,
    input  wb_stall, flush, chk_reg1, chk_reg2, chk_reg3, chk_reg4,
    output in_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
    output chk_hit, count, err_overflow
  );

  modport master (
    output in_valid1, in_rd1, in_data1, in_valid2, in_rd2, in_data2,
    output wb_stall, flush, chk_reg1, chk_reg2, chk_reg3, chk_reg4,
    input  in_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
    input  chk_hit, count, err_overflow
  );
endinterface

// File: rtl/wb_queue.sv
// Dual-issue writeback queue: circular buffer of {rd, data} that accepts up to two
// results per cycle and drains up to two per cycle into the register file.
module wb_queue #(
  parameter int DEPTH = 8
) (
  input logic      clk,
  input logic      rst,
  wb_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic          in_ready;
  logic          offer1, offer2;
  logic          acc1, acc2;
  logic          wr1, wr2;
  logic [1:0]    n_acc, n_drain;
  logic [PW-1:0] head_p1, slot2_idx;
  logic [DEPTH-1:0] occupied;
  logic [4:0]    chk_reg [4];

  // Readiness looks only at registered occupancy so the producer never depends
  // on this cycle's drain decision.
  assign in_ready = (count_reg <= CW'(DEPTH - 2));

  assign offer1 = q.in_valid1 && (q.in_rd1 != 5'd0);
  assign offer2 = q.in_valid2 && (q.in_rd2 != 5'd0);
  assign acc1   = offer1 && in_ready && !q.flush;
  assign acc2   = offer2 && in_ready && !q.flush;

  assign wr1 = (count_reg != '0) && !q.wb_stall && !q.flush;
  assign wr2 = (count_reg >= CW'(2)) && !q.wb_stall && !q.flush;

  assign n_acc   = {1'b0, acc1} + {1'b0, acc2};
  assign n_drain = {1'b0, wr1} + {1'b0, wr2};

  assign head_p1   = head_reg + PW'(1);
  assign slot2_idx = acc1 ? (tail_reg + PW'(1)) : tail_reg;

  assign head_next  = head_reg + PW'(n_drain);
  assign tail_next  = tail_reg + PW'(n_acc);
  assign count_next = count_reg + CW'(n_acc) - CW'(n_drain);
  assign err_next   = err_reg | ((offer1 | offer2) & ~in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (q.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= err_next;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Slot 2 lands one past slot 1 when both are accepted, so the indices never collide.
  always_ff @(posedge clk) begin
    if (acc1) begin
      mem_rd[tail_reg]   <= q.in_rd1;
      mem_data[tail_reg] <= q.in_data1;
    end
    if (acc2) begin
      mem_rd[slot2_idx]   <= q.in_rd2;
      mem_data[slot2_idx] <= q.in_data2;
    end
  end

  assign q.in_ready     = in_ready;
  assign q.reg_write    = wr1;
  assign q.regd         = mem_rd[head_reg];
  assign q.write_data   = mem_data[head_reg];
  assign q.reg_write2   = wr2;
  assign q.regd2        = mem_rd[head_p1];
  assign q.write_data2  = mem_data[head_p1];
  assign q.count        = count_reg;
  assign q.err_overflow = err_reg;

  assign chk_reg[0] = q.chk_reg1;
  assign chk_reg[1] = q.chk_reg2;
  assign chk_reg[2] = q.chk_reg3;
  assign chk_reg[3] = q.chk_reg4;

  // An entry is live when its distance from head (mod DEPTH) is below count.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_occ
      logic [PW-1:0] offs;
      assign offs         = PW'(gi) - head_reg;
      assign occupied[gi] = ({1'b0, offs} < count_reg);
    end

    for (gi = 0; gi < 4; gi++) begin : g_hit
      logic [DEPTH-1:0] match;
      for (gj = 0; gj < DEPTH; gj++) begin : g_ent
        assign match[gj] = occupied[gj] && (mem_rd[gj] == chk_reg[gi]);
      end
      assign q.chk_hit[gi] = (chk_reg[gi] != 5'd0) && (|match);
    end
  endgenerate
endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue: the stimulus stages accepted results,
// a negedge monitor compares DUT outputs against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;

  wb_queue_if #(.DEPTH(DEPTH)) q ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t exp_q[$];
  ent_t stage_q[$];
  bit   stage_err;
  bit   err_model;
  bit   armed;
  int   n_vec;
  int   n_miss;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cyc(input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                     input bit v2, input logic [4:0] r2, input logic [31:0] d2,
                     input bit st, input bit fl, input bit rs, input logic [4:0] c1);
    bit rdy;
    @(posedge clk);
    #1;
    q.in_valid1 = v1;
    q.in_rd1    = r1;
    q.in_data1  = d1;
    q.in_valid2 = v2;
    q.in_rd2    = r2;
    q.in_data2  = d2;
    q.wb_stall  = st;
    q.flush     = fl;
    rst         = rs;
    q.chk_reg1  = c1;
    q.chk_reg2  = 5'($urandom_range(0, 7));
    q.chk_reg3  = 5'($urandom_range(0, 7));
    q.chk_reg4  = 5'($urandom_range(0, 7));
    rdy = (exp_q.size() <= DEPTH - 2);
    if (!rs) begin
      if (rdy && !fl) begin
        if (v1 && r1 != 5'd0) stage_q.push_back('{rd: r1, data: d1});
        if (v2 && r2 != 5'd0) stage_q.push_back('{rd: r2, data: d2});
      end
      if (!rdy && ((v1 && r1 != 5'd0) || (v2 && r2 != 5'd0))) stage_err = 1'b1;
    end
  endtask

  task automatic idle(input bit st, input logic [4:0] c1);
    cyc(1'b0, 5'd0, $urandom, 1'b0, 5'd0, $urandom, st, 1'b0, 1'b0, c1);
  endtask

  // Monitor / scoreboard
  initial begin
    int       sz;
    bit       w1, w2;
    logic [3:0] hm;
    logic [4:0] cr [4];
    forever begin
      @(negedge clk);
      sz = exp_q.size();
      w1 = (sz >= 1) && !q.wb_stall && !q.flush;
      w2 = (sz >= 2) && !q.wb_stall && !q.flush;
      if (armed) begin
        check("count", 64'(q.count), 64'(sz));
        check("in_ready", 64'(q.in_ready), 64'(sz <= DEPTH - 2));
        check("err_overflow", 64'(q.err_overflow), 64'(err_model));
        cr[0] = q.chk_reg1; cr[1] = q.chk_reg2; cr[2] = q.chk_reg3; cr[3] = q.chk_reg4;
        hm = '0;
        for (int i = 0; i < 4; i++)
          for (int k = 0; k < sz; k++)
            if (cr[i] != 5'd0 && exp_q[k].rd == cr[i]) hm[i] = 1'b1;
        check("chk_hit", 64'(q.chk_hit), 64'(hm));
        if (!rst) begin
          check("reg_write", 64'(q.reg_write), 64'(w1));
          check("reg_write2", 64'(q.reg_write2), 64'(w2));
          if (w1) begin
            check("port1", 64'({q.regd, q.write_data}), 64'(exp_q[0]));
            $display("wb1 rd=%0d data=%08h", q.regd, q.write_data);
          end
          if (w2) begin
            check("port2", 64'({q.regd2, q.write_data2}), 64'(exp_q[1]));
            $display("wb2 rd=%0d data=%08h", q.regd2, q.write_data2);
          end
        end
      end
      if (rst) begin
        exp_q.delete();
        err_model = 1'b0;
        armed     = 1'b1;
      end else if (armed) begin
        if (q.flush) exp_q.delete();
        else begin
          if (w1) void'(exp_q.pop_front());
          if (w2) void'(exp_q.pop_front());
        end
        foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
        err_model = err_model | stage_err;
      end
      stage_q.delete();
      stage_err = 1'b0;
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; armed = 1'b0; err_model = 1'b0; stage_err = 1'b0;
    rst = 1'b1;
    q.in_valid1 = 0; q.in_rd1 = 0; q.in_data1 = 0;
    q.in_valid2 = 0; q.in_rd2 = 0; q.in_data2 = 0;
    q.wb_stall = 0; q.flush = 0;
    q.chk_reg1 = 0; q.chk_reg2 = 0; q.chk_reg3 = 0; q.chk_reg4 = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    #1;
    check("rst_count", 64'(q.count), 64'd0);
    check("rst_err", 64'(q.err_overflow), 64'd0);
    check("rst_rw", 64'(q.reg_write), 64'd0);

    // Single write
    cyc(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    #1;
    check("single_rw", 64'(q.reg_write), 64'd1);
    check("single_regd", 64'(q.regd), 64'd5);
    check("single_data", 64'(q.write_data), 64'hA5A5A5A5);
    check("single_rw2", 64'(q.reg_write2), 64'd0);
    idle(0, 0);
    #1;
    check("single_drained", 64'(q.count), 64'd0);

    // Same-destination pair
    cyc(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 0, 0, 0, 0);
    idle(0, 5'd7);
    #1;
    check("pair_p1", 64'({q.regd, q.write_data}), 64'({5'd7, 32'd1}));
    check("pair_p2", 64'({q.regd2, q.write_data2}), 64'({5'd7, 32'd2}));
    check("pair_hit", 64'(q.chk_hit[0]), 64'd1);
    idle(0, 0);

    // x0 drop
    cyc(1, 5'd0, 32'hDEAD, 1, 5'd3, 32'd9, 0, 0, 0, 0);
    idle(0, 0);
    #1;
    check("x0_count", 64'(q.count), 64'd1);
    check("x0_p1", 64'({q.regd, q.write_data}), 64'({5'd3, 32'd9}));
    idle(0, 0);

    // Fill under stall, overflow, then drain with wrap
    for (int i = 0; i < 4; i++)
      cyc(1, 5'(2*i+1), 32'(100+2*i), 1, 5'(2*i+2), 32'(101+2*i), 1, 0, 0, 0);
    cyc(1, 5'd9, 32'd200, 1, 5'd10, 32'd201, 1, 0, 0, 0);
    #1;
    check("fill_count", 64'(q.count), 64'd8);
    check("fill_ready", 64'(q.in_ready), 64'd0);
    idle(1, 0);
    #1;
    check("ovf_err", 64'(q.err_overflow), 64'd1);
    check("ovf_count", 64'(q.count), 64'd8);
    for (int i = 0; i < 5; i++) idle(0, 0);

    // Flush with valid inputs
    cyc(1, 5'd1, 32'd11, 1, 5'd2, 32'd12, 1, 0, 0, 0);
    cyc(1, 5'd3, 32'd13, 1, 5'd4, 32'd14, 1, 0, 0, 0);
    cyc(1, 5'd5, 32'd15, 0, 5'd0, 32'd0, 1, 0, 0, 0);
    cyc(1, 5'd6, 32'd16, 1, 5'd7, 32'd17, 0, 1, 0, 0);
    #1;
    check("flush_pre_count", 64'(q.count), 64'd5);
    check("flush_no_write", 64'(q.reg_write | q.reg_write2), 64'd0);
    idle(0, 0);
    #1;
    check("flush_count", 64'(q.count), 64'd0);

    // Reset mid-operation
    cyc(1, 5'd1, 32'd21, 1, 5'd2, 32'd22, 1, 0, 0, 0);
    cyc(1, 5'd3, 32'd23, 1, 5'd4, 32'd24, 1, 0, 0, 0);
    cyc(1, 5'd5, 32'd25, 0, 5'd0, 32'd0, 1, 0, 0, 0);
    cyc(1, 5'd6, 32'd26, 1, 5'd7, 32'd27, 0, 0, 1, 0);
    idle(0, 0);
    #1;
    check("reset_count", 64'(q.count), 64'd0);
    check("reset_err", 64'(q.err_overflow), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
          $urandom_range(0, 149) == 0, 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) idle(0, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
